// File: rtl/ddr_in_capture.sv
// DDR input capture for the HyperRAM read path: samples din on both clock edges,
// orders each beat pair by a slippable phase and packs PACK pairs into one word.
module ddr_in_capture #(
  parameter int WIDTH = 8,
  parameter int PACK  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          din,
  input  logic                      cap_en,
  input  logic                      slip,
  output logic [WIDTH-1:0]          beat0,
  output logic [WIDTH-1:0]          beat1,
  output logic                      pair_vld,
  output logic                      phase,
  output logic [2*WIDTH*PACK-1:0]   word,
  output logic                      word_vld,
  output logic [15:0]               word_cnt
);

  localparam int PW = 2 * WIDTH;
  localparam int WW = PW * PACK;
  localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PACK - 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] f_q;
  logic [WIDTH-1:0] f_prev_q;
  logic             cap_q;
  logic             slip_q;

  logic [WIDTH-1:0] beat0_q, beat0_d;
  logic [WIDTH-1:0] beat1_q, beat1_d;
  logic             pair_vld_q, pair_vld_d;
  logic             phase_q, phase_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    part_q, part_d;
  logic [WW-1:0]    word_q, word_d;
  logic             word_vld_q, word_vld_d;
  logic [15:0]      word_cnt_q, word_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q      <= '0;
      f_prev_q <= '0;
      cap_q    <= 1'b0;
      slip_q   <= 1'b0;
    end else begin
      r_q      <= din;
      f_prev_q <= f_q;
      cap_q    <= cap_en;
      slip_q   <= slip;
    end
  end

  // The only negative-edge flop: the beat between two rising edges.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      f_q <= '0;
    end else begin
      f_q <= din;
    end
  end

  // A slip toggles which sample leads and voids the pair straddling the change.
  always_comb begin
    phase_d    = phase_q ^ slip_q;
    pair_vld_d = cap_q & ~slip_q;
    if (phase_d) begin
      beat0_d = f_prev_q;
      beat1_d = r_q;
    end else begin
      beat0_d = r_q;
      beat1_d = f_q;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    part_d     = part_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    word_cnt_d = word_cnt_q;
    if (slip_q) begin
      cnt_d  = '0;
      part_d = '0;
    end else if (pair_vld_q) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt_q == CW'(i)) begin
          part_d[i*PW +: PW] = {beat1_q, beat0_q};
        end else begin
          part_d[i*PW +: PW] = part_q[i*PW +: PW];
        end
      end
      if (cnt_q == CNT_LAST) begin
        cnt_d      = '0;
        word_d     = part_d;
        word_vld_d = 1'b1;
        word_cnt_d = word_cnt_q + 16'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      word_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat0_q    <= '0;
      beat1_q    <= '0;
      pair_vld_q <= 1'b0;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      part_q     <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      word_cnt_q <= 16'd0;
    end else begin
      beat0_q    <= beat0_d;
      beat1_q    <= beat1_d;
      pair_vld_q <= pair_vld_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      part_q     <= part_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign beat0    = beat0_q;
  assign beat1    = beat1_q;
  assign pair_vld = pair_vld_q;
  assign phase    = phase_q;
  assign word     = word_q;
  assign word_vld = word_vld_q;
  assign word_cnt = word_cnt_q;

  ddr_in_capture_chk u_chk (
    .clk_i      (clk),
    .reset_i    (reset),
    .pair_vld_i (pair_vld_q),
    .word_vld_i (word_vld_q),
    .word_cnt_i (word_cnt_q)
  );

endmodule

// Packer invariants: a word strobe always follows a valid pair and steps the counter.
module ddr_in_capture_chk (
  input logic        clk_i,
  input logic        reset_i,
  input logic        pair_vld_i,
  input logic        word_vld_i,
  input logic [15:0] word_cnt_i
);

  a_word_follows_pair: assert property (@(posedge clk_i) disable iff (reset_i)
    word_vld_i |-> $past(pair_vld_i));

  a_word_cnt_steps: assert property (@(posedge clk_i) disable iff (reset_i)
    word_vld_i |-> (word_cnt_i == 16'($past(word_cnt_i) + 16'd1)));

endmodule
